mem_burst_engine: RTL and testbench
===================================

# mem_burst_engine

Executes one main-memory burst transaction per command from the output-stationary arbiter, between the granted PE core and the main memory port. Accepts base address, direction, burst length and one-hot core grant. Issues per-beat addresses and steers write data (core to memory) or read data (memory to core). Pulses done when the burst completes, so the arbiter can re-arbitrate.

## Interface
- MAIN_MEM_ADDR_WIDTH, 32, main memory address width
- DATA_WIDTH, 16, data beat width
- NUM_CORES, 4, number of PE array cores
- BURST_WIDTH, 6, burst length field width (max burst 2^BURST_WIDTH-1 beats)

Clock and reset: one clock; reset is asynchronous and active-low.

- w_clock  in  1  clock; all state changes on rising edge
- w_reset_n  in  1  asynchronous active-low reset
- w_cmd_valid  in  1  arbiter presents a command
- w_cmd_ready  out  1  engine idle; command accepted when valid&ready
- w_cmd_addr  in  MAIN_MEM_ADDR_WIDTH  burst base address
- w_cmd_rw  in  1  1 = memory read (mem→core), 0 = memory write (core→mem)
- w_cmd_burst  in  BURST_WIDTH  beats in burst
- w_cmd_grant  in  NUM_CORES  one-hot target core
- w_core_wdata  in  NUM_CORES*DATA_WIDTH  per-core write data, core i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- w_core_wvalid  in  NUM_CORES  per-core write data valid
- w_core_wready  out  NUM_CORES  write beat consumed from core i
- w_core_rdata  out  DATA_WIDTH  read data, shared bus
- w_core_rvalid  out  NUM_CORES  read beat valid for core i
- w_mem_req  out  1  beat request to memory
- w_mem_rw  out  1  direction of current request (same encoding as w_cmd_rw)
- w_mem_addr  out  MAIN_MEM_ADDR_WIDTH  beat address
- w_mem_wdata  out  DATA_WIDTH  write beat data
- w_mem_gnt  in  1  memory accepts the beat this cycle (w_mem_req & w_mem_gnt)
- w_mem_rdata  in  DATA_WIDTH  returned read data
- w_mem_rvalid  in  1  returned read beat valid (in order, ≥1 cycle after accept)
- w_done  out  1  one-cycle pulse at burst completion
- w_err  out  1  sticky: w_mem_rvalid received while no read outstanding

## Operation
- States: IDLE, WRITE, READ_ISSUE, READ_DRAIN, DONE.
- IDLE: w_cmd_ready=1. On accept, latch addr, rw, burst and sel. sel is the lowest set bit of grant.
- Accept with burst==0 or grant==0 goes to DONE; no memory traffic.
- Otherwise go to WRITE (rw=0) or READ_ISSUE (rw=1). Clear issue count and return count.
- WRITE:
  - w_mem_req = w_core_wvalid[sel].
  - w_mem_wdata = core sel slice.
  - w_core_wready[sel] = w_mem_req & w_mem_gnt. Other wready bits are 0.
  - Each accepted beat increments the issue count.
  - After beat burst-1 is accepted, go to DONE.
- READ_ISSUE:
  - w_mem_req=1. Each req&gnt increments the issue count.
  - After the last address is accepted, go to READ_DRAIN, or to DONE if all beats have already returned.
- Returns (READ_ISSUE or READ_DRAIN):
  - On each w_mem_rvalid, register w_mem_rdata to w_core_rdata and set w_core_rvalid[sel] one cycle later.
  - Increment the return count.
- READ_DRAIN: when the return count reaches burst (including the current rvalid), go to DONE.
- DONE: w_done=1 for one cycle, then IDLE. The last read beat's w_core_rvalid coincides with w_done.
- w_mem_addr = base + issue count, modulo 2^MAIN_MEM_ADDR_WIDTH (wraps silently).
- w_mem_rw = latched rw.
- Counters are BURST_WIDTH+1 bits; no overflow is possible.
- w_mem_rvalid in IDLE, WRITE or DONE, or with return count == burst: data dropped, w_err set. w_err clears only on reset.
- w_cmd_valid while not ready is ignored. Command inputs are sampled only at accept.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, all counters 0, w_err=0, w_core_rvalid=0, w_core_rdata=0.
  - Combinational outputs during reset: w_cmd_ready=1; w_mem_req, w_core_wready, w_done all 0. w_mem_addr, w_mem_rw, w_mem_wdata are 0.
- Reset mid-burst aborts immediately: no done pulse; outstanding reads discarded without w_err.
- w_mem_req, w_mem_addr, w_mem_wdata and w_core_wready are combinational from state/counters and the current w_core_wvalid.
- w_core_rvalid and w_core_rdata are registered.
- Accept at edge T: first w_mem_req possible in cycle T+1.
- Write burst N with gnt and wvalid always high: beats in cycles T+1..T+N, w_done in T+N+1, w_cmd_ready in T+N+2.
- Read burst N, gnt always high, fixed read latency L: last w_core_rvalid and w_done in cycle T+N+L+1 (with L counted from accept), ready the next cycle.
- Zero-length command: w_done at T+1, ready at T+2.

## Test plan
- Write burst: addr 0x100, burst 4, grant 0b0100, wvalid and gnt always high. Expect:
  - mem addr 0x100..0x103 in 4 consecutive cycles with core 2 data;
  - wready only on bit 2;
  - w_done 1 cycle after the last beat.
- Read burst: addr 0x20, burst 3, grant 0b0001, read latency 2. Expect:
  - 3 consecutive addresses issued;
  - w_core_rvalid[0] for 3 beats, in order, with matching data;
  - w_done aligned with the last rvalid.
- Backpressure: write burst 3 with gnt toggling 1,0,1,0,1 and wvalid[sel] dropping for one cycle. Expect:
  - exactly 3 beats, no address skipped or repeated;
  - w_done after the third beat.
- Edge commands:
  - addr 0xFFFF_FFFE, burst 3: addresses FFFF_FFFE, FFFF_FFFF, 0000_0000.
  - burst 0 and grant 0 commands: w_done at T+1, no w_mem_req.
  - grant 0b1010: core 1 selected.
- Errors and reset:
  - Stray w_mem_rvalid in IDLE: w_err=1 and held.
  - w_reset_n low mid read burst: all outputs to reset values immediately, w_err=0, next command executes normally.

Source files
------------

// File: rtl/mem_burst_engine.sv
// mem_burst_engine: runs one main-memory burst per arbiter command. Write bursts
// move beats from the granted core to memory. Read bursts issue addresses and
// steer the returned beats back to that core. A done pulse releases the arbiter.
module mem_burst_engine #(
    parameter int unsigned MAIN_MEM_ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH          = 16,
    parameter int unsigned NUM_CORES           = 4,
    parameter int unsigned BURST_WIDTH         = 6
) (
    input  logic                            w_clock,
    input  logic                            w_reset_n,
    input  logic                            w_cmd_valid,
    output logic                            w_cmd_ready,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0]  w_cmd_addr,
    input  logic                            w_cmd_rw,
    input  logic [BURST_WIDTH-1:0]          w_cmd_burst,
    input  logic [NUM_CORES-1:0]            w_cmd_grant,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] w_core_wdata,
    input  logic [NUM_CORES-1:0]            w_core_wvalid,
    output logic [NUM_CORES-1:0]            w_core_wready,
    output logic [DATA_WIDTH-1:0]           w_core_rdata,
    output logic [NUM_CORES-1:0]            w_core_rvalid,
    output logic                            w_mem_req,
    output logic                            w_mem_rw,
    output logic [MAIN_MEM_ADDR_WIDTH-1:0]  w_mem_addr,
    output logic [DATA_WIDTH-1:0]           w_mem_wdata,
    input  logic                            w_mem_gnt,
    input  logic [DATA_WIDTH-1:0]           w_mem_rdata,
    input  logic                            w_mem_rvalid,
    output logic                            w_done,
    output logic                            w_err
);

    localparam int unsigned SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W = BURST_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_ISSUE,
        S_READ_DRAIN,
        S_DONE
    } state_e;

    state_e                         state_q, state_d;
    logic [MAIN_MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                           rw_q, rw_d;
    logic [BURST_WIDTH-1:0]         burst_q, burst_d;
    logic [SEL_W-1:0]               sel_q, sel_d;
    logic [CNT_W-1:0]               issue_q, issue_d;
    logic [CNT_W-1:0]               ret_q, ret_d;
    logic                           err_q, err_d;
    logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
    logic [NUM_CORES-1:0]           rvalid_q, rvalid_d;

    logic [SEL_W-1:0]      grant_sel;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_wvalid;
    logic [NUM_CORES-1:0]  sel_onehot;
    logic [CNT_W-1:0]      burst_ext;
    logic                  issue_last;
    logic                  ret_open;

    // Lowest set grant bit picks the target core
    always_comb begin
        grant_sel = '0;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (w_cmd_grant[i]) grant_sel = SEL_W'(i);
        end
    end

    // Select the latched core's write lane
    always_comb begin
        sel_wdata  = '0;
        sel_wvalid = 1'b0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_wdata  = w_core_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wvalid = w_core_wvalid[i];
            end
        end
    end

    assign sel_onehot  = NUM_CORES'(1) << sel_q;
    assign burst_ext   = CNT_W'(burst_q);
    assign issue_last  = (issue_q + CNT_W'(1)) == burst_ext;
    assign ret_open    = ((state_q == S_READ_ISSUE) || (state_q == S_READ_DRAIN))
                         && (ret_q != burst_ext);
    assign w_mem_addr    = addr_q + MAIN_MEM_ADDR_WIDTH'(issue_q);
    assign w_mem_rw      = rw_q;
    assign w_core_rdata  = rdata_q;
    assign w_core_rvalid = rvalid_q;
    assign w_err         = err_q;

    // Next-state, return handling and combinational handshake outputs
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rw_d          = rw_q;
        burst_d       = burst_q;
        sel_d         = sel_q;
        issue_d       = issue_q;
        ret_d         = ret_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        rvalid_d      = '0;
        w_cmd_ready   = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_wdata   = '0;
        w_core_wready = '0;
        w_done        = 1'b0;

        // A return with no read outstanding is dropped and flagged
        if (w_mem_rvalid) begin
            if (ret_open) begin
                ret_d    = ret_q + CNT_W'(1);
                rdata_d  = w_mem_rdata;
                rvalid_d = sel_onehot;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (w_cmd_valid) begin
                    addr_d  = w_cmd_addr;
                    rw_d    = w_cmd_rw;
                    burst_d = w_cmd_burst;
                    sel_d   = grant_sel;
                    issue_d = '0;
                    ret_d   = '0;
                    if ((w_cmd_burst == '0) || (w_cmd_grant == '0)) begin
                        state_d = S_DONE;
                    end else if (w_cmd_rw) begin
                        state_d = S_READ_ISSUE;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_mem_req   = sel_wvalid;
                w_mem_wdata = sel_wdata;
                if (w_mem_req && w_mem_gnt) begin
                    w_core_wready = sel_onehot;
                    issue_d       = issue_q + CNT_W'(1);
                    if (issue_last) state_d = S_DONE;
                end
            end
            S_READ_ISSUE: begin
                w_mem_req = 1'b1;
                if (w_mem_gnt) begin
                    issue_d = issue_q + CNT_W'(1);
                    if (issue_last) begin
                        state_d = (ret_d == burst_ext) ? S_DONE : S_READ_DRAIN;
                    end
                end
            end
            S_READ_DRAIN: begin
                if (ret_d == burst_ext) state_d = S_DONE;
            end
            S_DONE: begin
                w_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            burst_q  <= '0;
            sel_q    <= '0;
            issue_q  <= '0;
            ret_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            burst_q  <= burst_d;
            sel_q    <= sel_d;
            issue_q  <= issue_d;
            ret_q    <= ret_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_burst_engine.sv
// Bench for mem_burst_engine: directed command table, random commands against
// a transaction-level memory/core model, plus stray-return and mid-burst reset.
`timescale 1ns/1ps
module tb_mem_burst_engine;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned NC = 4;
    localparam int unsigned BW = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             w_cmd_valid, w_cmd_ready, w_cmd_rw;
    logic [AW-1:0]    w_cmd_addr, w_mem_addr;
    logic [BW-1:0]    w_cmd_burst;
    logic [NC-1:0]    w_cmd_grant, w_core_wvalid, w_core_wready, w_core_rvalid;
    logic [NC*DW-1:0] w_core_wdata;
    logic [DW-1:0]    w_core_rdata, w_mem_wdata, w_mem_rdata;
    logic             w_mem_req, w_mem_rw, w_mem_gnt, w_mem_rvalid, w_done, w_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic [BW-1:0] burst;
        logic [NC-1:0] grant;
        int            sel;      // expected selected core
        int            gmode;    // 0 gnt high, 1 gnt toggles 1,0,1.., 2 random
        int            wmode;    // 0 wvalid high, 1 drop in cycle 2, 2 random
        int            lat;      // memory read latency
        int            done_at;  // expected done cycle after accept, -1 = not fixed
    } vec_t;

    vec_t tbl[11];

    mem_burst_engine dut (
        .w_clock       (clk),
        .w_reset_n     (rst_n),
        .w_cmd_valid   (w_cmd_valid),
        .w_cmd_ready   (w_cmd_ready),
        .w_cmd_addr    (w_cmd_addr),
        .w_cmd_rw      (w_cmd_rw),
        .w_cmd_burst   (w_cmd_burst),
        .w_cmd_grant   (w_cmd_grant),
        .w_core_wdata  (w_core_wdata),
        .w_core_wvalid (w_core_wvalid),
        .w_core_wready (w_core_wready),
        .w_core_rdata  (w_core_rdata),
        .w_core_rvalid (w_core_rvalid),
        .w_mem_req     (w_mem_req),
        .w_mem_rw      (w_mem_rw),
        .w_mem_addr    (w_mem_addr),
        .w_mem_wdata   (w_mem_wdata),
        .w_mem_gnt     (w_mem_gnt),
        .w_mem_rdata   (w_mem_rdata),
        .w_mem_rvalid  (w_mem_rvalid),
        .w_done        (w_done),
        .w_err         (w_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return DW'(a) ^ DW'(a >> 16) ^ 16'h5A3C;
    endfunction

    function automatic int low_bit(input logic [NC-1:0] g);
        int r = 0;
        for (int i = int'(NC) - 1; i >= 0; i--) if (g[i]) r = i;
        return r;
    endfunction

    function automatic vec_t mk(input logic [AW-1:0] a, input logic rw, input int b,
                                input logic [NC-1:0] g, input int s, input int gm,
                                input int wm, input int lat, input int dn);
        vec_t v;
        v.addr = a; v.rw = rw; v.burst = BW'(b); v.grant = g; v.sel = s;
        v.gmode = gm; v.wmode = wm; v.lat = lat; v.done_at = dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        w_cmd_valid = 1'b0; w_cmd_addr = '0; w_cmd_rw = 1'b0; w_cmd_burst = '0;
        w_cmd_grant = '0; w_core_wdata = '0; w_core_wvalid = '0; w_mem_gnt = 1'b0;
        w_mem_rdata = '0; w_mem_rvalid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},  64'(w_cmd_ready), 64'(1));
        chk({tag, "_req"},    64'(w_mem_req), 64'(0));
        chk({tag, "_wready"}, 64'(w_core_wready), 64'(0));
        chk({tag, "_done"},   64'(w_done), 64'(0));
        chk({tag, "_addr"},   64'(w_mem_addr), 64'(0));
        chk({tag, "_rw"},     64'(w_mem_rw), 64'(0));
        chk({tag, "_wdata"},  64'(w_mem_wdata), 64'(0));
        chk({tag, "_rvalid"}, 64'(w_core_rvalid), 64'(0));
        chk({tag, "_rdata"},  64'(w_core_rdata), 64'(0));
        chk({tag, "_err"},    64'(w_err), 64'(0));
    endtask

    // One command end to end against a transaction-level memory and core model
    task automatic run_cmd(input vec_t v);
        int            beats, n_iss, n_ret, last_beat, last_ret, done_k, sel;
        int            due_q[$];
        logic [DW-1:0] dat_q[$];
        logic [NC-1:0] oh, wv;
        logic [NC*DW-1:0] wd;
        logic [DW-1:0] exp_rd, drv_slice, rd_d;
        logic          exp_rv, gnt_d, wv_sel, rv_d, exp_req, exp_done;
        logic [AW-1:0] beat_addr;

        sel       = v.sel;
        oh        = NC'(1) << sel;
        beats     = ((v.burst == '0) || (v.grant == '0)) ? 0 : int'(v.burst);
        n_iss     = 0; n_ret = 0; last_beat = -10; last_ret = -10; done_k = -1;
        exp_rv    = 1'b0; exp_rd = '0;

        @(negedge clk);
        drive_idle();
        w_cmd_valid = 1'b1; w_cmd_addr = v.addr; w_cmd_rw = v.rw;
        w_cmd_burst = v.burst; w_cmd_grant = v.grant;
        #1 chk("cmd_ready", 64'(w_cmd_ready), 64'(1));

        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            // command inputs are garbage while busy and must be ignored
            w_cmd_valid = ($urandom % 2) != 0;
            w_cmd_addr  = AW'($urandom);
            w_cmd_rw    = ($urandom % 2) != 0;
            w_cmd_burst = BW'($urandom);
            w_cmd_grant = NC'($urandom);
            case (v.gmode)
                0:       gnt_d = 1'b1;
                1:       gnt_d = (k % 2) == 1;
                default: gnt_d = ($urandom % 3) != 0;
            endcase
            case (v.wmode)
                0:       wv_sel = 1'b1;
                1:       wv_sel = (k != 2);
                default: wv_sel = ($urandom % 4) != 0;
            endcase
            wv = NC'($urandom);
            wv[sel] = wv_sel;
            for (int i = 0; i < int'(NC); i++) wd[i*DW +: DW] = DW'($urandom);
            drv_slice = wd[sel*DW +: DW];
            rv_d = (due_q.size() > 0) && (due_q[0] == k);
            rd_d = rv_d ? dat_q[0] : DW'($urandom);
            w_mem_gnt = gnt_d; w_core_wvalid = wv; w_core_wdata = wd;
            w_mem_rvalid = rv_d; w_mem_rdata = rd_d;

            exp_req  = (n_iss < beats) && (v.rw || wv_sel);
            exp_done = (beats == 0) ? (k == 1) :
                       (v.rw ? ((n_ret == beats) && (last_ret == k - 1))
                             : ((n_iss == beats) && (last_beat == k - 1)));
            #1;
            chk("mem_req", 64'(w_mem_req), 64'(exp_req));
            chk("done", 64'(w_done), 64'(exp_done));
            chk("wready", 64'(w_core_wready), 64'((!v.rw && exp_req && gnt_d) ? oh : '0));
            chk("core_rvalid", 64'(w_core_rvalid), 64'(exp_rv ? oh : '0));
            if (exp_rv) chk("core_rdata", 64'(w_core_rdata), 64'(exp_rd));
            if (exp_req && gnt_d) begin
                beat_addr = v.addr + AW'(n_iss);
                chk("mem_addr", 64'(w_mem_addr), 64'(beat_addr));
                chk("mem_rw", 64'(w_mem_rw), 64'(v.rw));
                if (!v.rw) begin
                    chk("mem_wdata", 64'(w_mem_wdata), 64'(drv_slice));
                    last_beat = k;
                end else begin
                    due_q.push_back(k + v.lat);
                    dat_q.push_back(mem_data(beat_addr));
                end
                n_iss++;
            end
            if (rv_d) begin
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
                n_ret++;
                last_ret = k;
            end
            exp_rv = rv_d;
            exp_rd = rd_d;
            if (exp_done || w_done) begin
                done_k = k;
                break;
            end
        end

        if (done_k < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within 400 cycles, got none required one");
        end
        chk("beats", 64'(n_iss), 64'(beats));
        chk("returns", 64'(n_ret), 64'(v.rw ? beats : 0));
        if (v.done_at >= 0) chk("done_time", 64'(done_k), 64'(v.done_at));

        @(negedge clk);
        drive_idle();
        #1;
        chk("ready_after", 64'(w_cmd_ready), 64'(1));
        chk("done_once", 64'(w_done), 64'(0));
        chk("rvalid_after", 64'(w_core_rvalid), 64'(0));
        chk("err_clear", 64'(w_err), 64'(0));
    endtask

    initial begin
        vec_t rv;

        tbl[0]  = mk(32'h0000_0100, 1'b0,  4, 4'b0100, 2, 0, 0, 1,  5);
        tbl[1]  = mk(32'h0000_0020, 1'b1,  3, 4'b0001, 0, 0, 0, 2,  6);
        tbl[2]  = mk(32'h0000_0200, 1'b0,  3, 4'b0010, 1, 1, 1, 1,  6);
        tbl[3]  = mk(32'hFFFF_FFFE, 1'b0,  3, 4'b0001, 0, 0, 0, 1,  4);
        tbl[4]  = mk(32'hFFFF_FFFE, 1'b1,  3, 4'b1000, 3, 0, 0, 1,  5);
        tbl[5]  = mk(32'h0000_0040, 1'b0,  0, 4'b0001, 0, 0, 0, 1,  1);
        tbl[6]  = mk(32'h0000_0080, 1'b1,  5, 4'b0000, 0, 0, 0, 1,  1);
        tbl[7]  = mk(32'h0000_0300, 1'b0,  2, 4'b1010, 1, 0, 0, 1,  3);
        tbl[8]  = mk(32'h0000_0310, 1'b1,  2, 4'b1010, 1, 0, 0, 3,  6);
        tbl[9]  = mk(32'h0000_0007, 1'b1,  1, 4'b0001, 0, 0, 0, 1,  3);
        tbl[10] = mk(32'h0000_1000, 1'b1, 63, 4'b0100, 2, 0, 0, 4, 68);

        // Reset values while held in reset, with busy-looking inputs
        drive_idle();
        w_core_wvalid = '1; w_core_wdata = 64'h1234_5678_9ABC_DEF0; w_mem_gnt = 1'b1;
        #2 check_reset_vals("rst_init");
        repeat (2) @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        foreach (tbl[i]) run_cmd(tbl[i]);

        for (int n = 0; n < 25; n++) begin
            rv.addr    = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + AW'($urandom % 16)) : AW'($urandom);
            rv.rw      = ($urandom % 2) != 0;
            rv.burst   = BW'($urandom_range(0, 9));
            rv.grant   = NC'($urandom);
            rv.sel     = low_bit(rv.grant);
            rv.gmode   = 2;
            rv.wmode   = 2;
            rv.lat     = int'($urandom_range(1, 4));
            rv.done_at = -1;
            run_cmd(rv);
        end

        // Stray read return in idle is dropped and flags a sticky error
        @(negedge clk);
        drive_idle();
        w_mem_rvalid = 1'b1; w_mem_rdata = 16'hBEEF;
        @(negedge clk);
        w_mem_rvalid = 1'b0;
        #1;
        chk("err_set", 64'(w_err), 64'(1));
        chk("stray_rvalid", 64'(w_core_rvalid), 64'(0));
        repeat (3) @(negedge clk);
        #1 chk("err_held", 64'(w_err), 64'(1));

        // Reset in the middle of a read burst with beats in flight
        @(negedge clk);
        drive_idle();
        w_cmd_valid = 1'b1; w_cmd_addr = 32'h40; w_cmd_rw = 1'b1;
        w_cmd_burst = 6'd8; w_cmd_grant = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive_idle();
            w_mem_gnt    = 1'b1;
            w_mem_rvalid = (k >= 3);
            w_mem_rdata  = mem_data(AW'(32'h40 + AW'(k - 3)));
        end
        @(negedge clk);
        drive_idle();
        w_mem_gnt = 1'b1; w_core_wvalid = '1;
        #1;
        chk("pre_rst_rvalid", 64'(w_core_rvalid), 64'(4'b0001));
        chk("pre_rst_rdata", 64'(w_core_rdata), 64'(mem_data(32'h42)));
        chk("pre_rst_req", 64'(w_mem_req), 64'(1));
        #1 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        run_cmd(tbl[1]);
        run_cmd(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
